serial_master_port: RTL and testbench

//  Parametrised bit-serial bus master port: converts one parallel master request (addr/data/mode)

---
 rtl/serial_master_port.sv | 176 +++++++++++++++++
 tb/tb_serial_master_port.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_master_port.sv
// Bit-serial bus master port: arbitrates for the bus, shifts a split select/offset address
// MSB-first, then writes or reads one data word, with select timeout and bounded re-arbitration.
module serial_master_port #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int SEL_W     = 4,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              breq,
  input  logic              bgrant,
  output logic              mode,
  output logic              wr_bus,
  input  logic              rd_bus,
  output logic              master_valid,
  input  logic              slave_ready,
  output logic              master_ready,
  input  logic              slave_valid,
  input  logic              ack,
  input  logic              m_start,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wr_data,
  input  logic              m_mode,
  output logic              m_busy,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              m_rd_valid,
  output logic              m_done,
  output logic              m_err
);

  localparam int CNT_W = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
  localparam int TMO_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int RTY_W = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] SEL_LAST = CNT_W'(SEL_W - 1);
  localparam logic [CNT_W-1:0] REM_LAST = CNT_W'(ADDR_W - SEL_W - 1);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_FETCH, S_ADDR_SEL, S_ACK_WAIT,
    S_ADDR_REM, S_WR_DATA, S_RD_DATA, S_DONE, S_ERROR
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              mode;
  } req_t;

  state_t            state, state_nx;
  req_t              req;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-2:0] rd_shift;
  logic [DATA_W-1:0] rd_word;
  logic [CNT_W-1:0]  cnt;
  logic [TMO_W-1:0]  tmo;
  logic [RTY_W-1:0]  retry;
  logic              tmo_hit, retry_ok, tmo_retry, wr_xfer, rd_xfer;

  assign tmo_hit  = (tmo == TMO_LAST);
  assign retry_ok = (retry < RTY_MAX);
  assign wr_xfer  = master_valid & slave_ready;
  assign rd_xfer  = master_ready & slave_valid;
  assign rd_word  = {rd_shift, rd_bus};
  assign mode     = req.mode;
  assign m_busy   = (state != S_IDLE);
  assign wr_bus   = (state == S_IDLE)    ? 1'b0 :
                    (state == S_WR_DATA) ? data_sr[DATA_W-1] : addr_sr[ADDR_W-1];
  assign tmo_retry = (state == S_ADDR_SEL || state == S_ACK_WAIT) && (state_nx == S_REQ);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    breq         = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    m_done       = 1'b0;
    m_err        = 1'b0;
    m_rd_valid   = 1'b0;
    case (state)
      S_IDLE:     if (m_start) state_nx = S_REQ;
      S_REQ: begin
        breq = 1'b1;
        if (bgrant) state_nx = S_FETCH;
      end
      S_FETCH: begin
        breq     = 1'b1;
        state_nx = S_ADDR_SEL;
      end
      S_ADDR_SEL: begin
        breq         = 1'b1;
        master_valid = 1'b1;
        if (tmo_hit)                          state_nx = retry_ok ? S_REQ : S_ERROR;
        else if (slave_ready && cnt == SEL_LAST) state_nx = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        breq = 1'b1;
        if (ack)          state_nx = S_ADDR_REM;
        else if (tmo_hit) state_nx = retry_ok ? S_REQ : S_ERROR;
      end
      S_ADDR_REM: begin
        breq         = 1'b1;
        master_valid = 1'b1;
        if (slave_ready && cnt == REM_LAST) state_nx = req.mode ? S_WR_DATA : S_RD_DATA;
      end
      S_WR_DATA: begin
        breq         = 1'b1;
        master_valid = 1'b1;
        if (slave_ready && cnt == DAT_LAST) state_nx = S_DONE;
      end
      S_RD_DATA: begin
        breq         = 1'b1;
        master_ready = 1'b1;
        if (slave_valid && cnt == DAT_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        m_done     = 1'b1;
        m_rd_valid = ~req.mode;
        state_nx   = S_IDLE;
      end
      S_ERROR: begin
        m_err    = 1'b1;
        state_nx = S_IDLE;
      end
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req       <= '0;
      addr_sr   <= '0;
      data_sr   <= '0;
      rd_shift  <= '0;
      m_rd_data <= '0;
      cnt       <= '0;
      tmo       <= '0;
      retry     <= '0;
    end else begin
      if (state == S_IDLE) retry <= '0;
      // Retries replay the request captured on the first FETCH, not the live inputs.
      if (state == S_FETCH) begin
        if (retry == '0) begin
          req     <= {m_addr, m_wr_data, m_mode};
          addr_sr <= m_addr;
          data_sr <= m_wr_data;
        end else begin
          addr_sr <= req.addr;
          data_sr <= req.data;
        end
        cnt <= '0;
        tmo <= '0;
      end
      if ((state == S_ADDR_SEL || state == S_ACK_WAIT) && !tmo_hit) tmo <= tmo + 1'b1;
      if (tmo_retry) retry <= retry + 1'b1;
      if (wr_xfer) begin
        if (state == S_WR_DATA) data_sr <= {data_sr[DATA_W-2:0], 1'b0};
        else                    addr_sr <= {addr_sr[ADDR_W-2:0], 1'b0};
      end
      if (rd_xfer) begin
        rd_shift <= rd_word[DATA_W-2:0];
        if (state_nx == S_DONE) m_rd_data <= rd_word;
      end
      if (wr_xfer || rd_xfer) cnt <= (state_nx != state) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_master_port.sv
// Randomized bench acting as arbiter and slave; the observed serial stream, pulses and
// timing are compared against a transaction-level model built from the address/data words.
module tb_serial_master_port;
  localparam int ADDR_W = 16, DATA_W = 8, SEL_W = 4, TIMEOUT = 64, MAX_RETRY = 3;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic breq, bgrant, mode, wr_bus, rd_bus, master_valid, slave_ready;
  logic master_ready, slave_valid, ack, m_start, m_mode, m_busy;
  logic m_rd_valid, m_done, m_err;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wr_data, m_rd_data;

  always #5 clk = ~clk;

  serial_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W),
                       .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rstn(rstn), .breq(breq), .bgrant(bgrant), .mode(mode), .wr_bus(wr_bus),
    .rd_bus(rd_bus), .master_valid(master_valid), .slave_ready(slave_ready),
    .master_ready(master_ready), .slave_valid(slave_valid), .ack(ack), .m_start(m_start),
    .m_addr(m_addr), .m_wr_data(m_wr_data), .m_mode(m_mode), .m_busy(m_busy),
    .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .m_done(m_done), .m_err(m_err));

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // observations of the last transaction
  bit              got_q[$];
  int              att_start[$];
  int              done_n, err_n, rdv_n, done_cyc, err_cyc, mode_bad;
  logic [DATA_W-1:0] rdv_data;
  logic            rdv_with_done;

  task automatic run_txn(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdat,
                         input logic md, input logic [DATA_W-1:0] rword, input int rdy_pct,
                         input int sv_pct, input int ack_att, input bit rnd_grant,
                         input int abort_bits);
    int  k, pos, ridx, cur_att, tail;
    bit  prev_hold, prev_bit, prev_mv, ended;
    got_q.delete(); att_start.delete();
    done_n = 0; err_n = 0; rdv_n = 0; done_cyc = 0; err_cyc = 0; mode_bad = 0;
    rdv_data = '0; rdv_with_done = 1'b0;
    k = 0; pos = 0; ridx = 0; cur_att = 0; tail = -1;
    prev_hold = 0; prev_bit = 0; prev_mv = 0; ended = 0;
    @(negedge clk);
    m_addr = addr; m_wr_data = wdat; m_mode = md; m_start = 1'b1;
    bgrant = 1'b0; slave_ready = 1'b0; slave_valid = 1'b0; ack = (ack_att == 0);
    #1 chk("breq_idle", breq, 1'b0);
    while (k < BUDGET) begin
      @(negedge clk);
      k++;
      m_start = 1'b0;
      if (k == 1) chk("breq_1cyc", breq, 1'b1);
      if (m_done) begin done_n++; done_cyc = k; end
      if (m_err)  begin err_n++;  err_cyc = k;  end
      if (m_rd_valid) begin rdv_n++; rdv_data = m_rd_data; rdv_with_done = m_done; end
      if ((m_done || m_err) && tail < 0) tail = 3;
      if (prev_hold && master_valid) chk("hold_bit", wr_bus, prev_bit);
      if (master_valid && mode !== md) mode_bad++;
      if (master_valid && !prev_mv) begin
        if (pos == 0) att_start.push_back(k);
        else if (pos == SEL_W && cur_att != ack_att) begin
          cur_att++; pos = 0; att_start.push_back(k);
        end
      end
      bgrant      = breq && (!rnd_grant || ($urandom % 2 == 0));
      slave_ready = ($urandom % 100) < rdy_pct;
      slave_valid = ($urandom % 100) < sv_pct;
      rd_bus      = (ridx < DATA_W) ? rword[DATA_W-1-ridx] : 1'($urandom);
      if (master_ready && slave_valid) ridx++;
      if (master_valid) begin
        // garbage on the request inputs must not leak into a running transaction
        m_start = 1'b1; m_addr = ~addr; m_wr_data = ~wdat; m_mode = ~md;
        if (slave_ready) begin
          got_q.push_back(wr_bus); pos++;
          if (abort_bits > 0 && got_q.size() == abort_bits) begin
            #2 rstn = 1'b0;
            #1 chk("abort_breq", breq, 1'b0);
            chk("abort_mv", master_valid, 1'b0);
            chk("abort_busy", m_busy, 1'b0);
            repeat (2) begin
              @(negedge clk);
              chk("abort_pulses", {m_done, m_err, m_rd_valid}, 3'b0);
            end
            chk("abort_rd_data", m_rd_data, '0);
            m_start = 1'b0; slave_ready = 1'b0;
            rstn = 1'b1;
            ended = 1;
            break;
          end
        end
      end
      ack = (cur_att == ack_att);
      prev_hold = master_valid && !slave_ready;
      prev_bit  = wr_bus;
      prev_mv   = master_valid;
      if (tail > 0) begin
        tail--;
        if (tail == 0) begin ended = 1; break; end
      end
    end
    chk("cycle_budget", ended, 1'b1);
    m_start = 1'b0; bgrant = 1'b0; slave_ready = 1'b0; slave_valid = 1'b0; ack = 1'b0;
    if (abort_bits == 0) chk("idle_after", m_busy, 1'b0);
  endtask

  // transaction-level expectation: failed attempts send only the select bits,
  // the acknowledged attempt sends the whole address then (for writes) the data word
  task automatic expect_txn(input string nm, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdat, input logic md,
                            input logic [DATA_W-1:0] rword, input int ack_att,
                            input bit exact);
    bit exp_q[$];
    logic [127:0] g, e;
    bit ok;
    int n_att;
    ok    = (ack_att <= MAX_RETRY);
    n_att = ok ? ack_att + 1 : MAX_RETRY + 1;
    for (int a = 0; a < n_att; a++) begin
      int nb;
      nb = (ok && a == n_att - 1) ? ADDR_W : SEL_W;
      for (int i = 0; i < nb; i++) exp_q.push_back(addr[ADDR_W-1-i]);
    end
    if (ok && md) for (int i = 0; i < DATA_W; i++) exp_q.push_back(wdat[DATA_W-1-i]);
    g = '0; e = '0;
    foreach (got_q[i]) g = {g[126:0], got_q[i]};
    foreach (exp_q[i]) e = {e[126:0], exp_q[i]};
    chk({nm, "_len"}, got_q.size(), exp_q.size());
    chk({nm, "_bits"}, g, e);
    chk({nm, "_done"}, done_n, ok ? 1 : 0);
    chk({nm, "_err"}, err_n, ok ? 0 : 1);
    chk({nm, "_rdv"}, rdv_n, (ok && !md) ? 1 : 0);
    chk({nm, "_attempts"}, att_start.size(), n_att);
    chk({nm, "_mode"}, mode_bad, 0);
    if (ok && !md) begin
      chk({nm, "_rd_data"}, rdv_data, rword);
      chk({nm, "_rdv_done"}, rdv_with_done, 1'b1);
    end
    if (exact && ok) chk({nm, "_done_cyc"}, done_cyc, ADDR_W + DATA_W + 4);
    if (exact && !ok) begin
      chk({nm, "_err_cyc"}, err_cyc - att_start[att_start.size()-1], TIMEOUT);
      for (int i = 1; i < att_start.size(); i++)
        chk({nm, "_period"}, att_start[i] - att_start[i-1], TIMEOUT + 2);
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, r;
    logic md;
    int ack_att;
    bgrant = 0; rd_bus = 0; slave_ready = 0; slave_valid = 0; ack = 0;
    m_start = 0; m_addr = '0; m_wr_data = '0; m_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {breq, mode, wr_bus, master_valid, master_ready, m_busy,
                     m_rd_valid, m_done, m_err}, '0);
    chk("rst_rd_data", m_rd_data, '0);
    @(negedge clk) rstn = 1'b1;

    run_txn(16'hA5C3, 8'h3C, 1'b1, 8'h00, 100, 0, 0, 0, 0);
    expect_txn("wr", 16'hA5C3, 8'h3C, 1'b1, 8'h00, 0, 1);
    run_txn(16'h1234, 8'h00, 1'b0, 8'hD2, 100, 50, 0, 0, 0);
    expect_txn("rd", 16'h1234, 8'h00, 1'b0, 8'hD2, 0, 0);
    run_txn(16'hA5C3, 8'h3C, 1'b1, 8'h00, 70, 0, 0, 1, 0);
    expect_txn("bp", 16'hA5C3, 8'h3C, 1'b1, 8'h00, 0, 0);
    run_txn(16'h5E71, 8'h96, 1'b1, 8'h00, 100, 0, 1, 0, 0);
    expect_txn("retry1", 16'h5E71, 8'h96, 1'b1, 8'h00, 1, 0);
    run_txn(16'hC0DE, 8'h11, 1'b1, 8'h00, 100, 0, 99, 0, 0);
    expect_txn("noack", 16'hC0DE, 8'h11, 1'b1, 8'h00, 99, 1);
    run_txn(16'h7F01, 8'hE4, 1'b0, 8'h5B, 100, 50, 0, 0, SEL_W + 3);
    run_txn(16'h0F0F, 8'hA9, 1'b1, 8'h00, 100, 0, 0, 0, 0);
    expect_txn("post_rst", 16'h0F0F, 8'hA9, 1'b1, 8'h00, 0, 0);

    for (int t = 0; t < 8; t++) begin
      a  = ADDR_W'($urandom);
      d  = DATA_W'($urandom);
      r  = DATA_W'($urandom);
      md = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       ack_att = 0;
        1:       ack_att = 1;
        default: ack_att = 7;
      endcase
      run_txn(a, d, md, r, 70, 50, ack_att, 1, 0);
      expect_txn("rand", a, d, md, r, ack_att, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
